// File: rtl/lsu_pkg.sv
// Shared LSU definitions: FSM states, size codes, default width.
// Used by lsu_mem_port and lsu_load_align.
package lsu_pkg;

  localparam int ADDR_W_DEF = 12;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC1,
    S_RD1,
    S_ACC2,
    S_RD2,
    S_RESP
  } state_t;

  function automatic logic be_legal(
    input logic [3:0] be
  );
    return (be == BE_B) || (be == BE_H) ||
           (be == BE_W);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shifts {hi,lo} by the byte offset,
// then masks and sign/zero extends to the access size.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  off,
  input  logic [3:0]  size,
  input  logic        uns,
  output logic [31:0] result
);

  logic [31:0] sh;
  logic        sb;
  logic        shb;

  always_comb begin
    sh     = 32'(data >> {off, 3'b000});
    sb     = ~uns & sh[7];
    shb    = ~uns & sh[15];
    result = sh;
    unique case (size)
      BE_B:    result = {{24{sb}}, sh[7:0]};
      BE_H:    result = {{16{shb}}, sh[15:0]};
      default: result = sh;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Core LSU to single-port word SRAM bridge with byte lanes.
// Define LSU_MISALIGNED_EN to split misaligned accesses in two.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [3:0]        req_be,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t state, state_n;

  logic              we_q;
  logic              uns_q;
  logic              err_q;
  logic [3:0]        be_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] word_q;
  logic [31:0]       lo_q;
  logic [31:0]       lo_n;
  logic [63:0]       al_data;
  logic [31:0]       al_res;

  logic              accept;
  logic [1:0]        off_in;
  logic [7:0]        m_in;
  logic              mis_in;
  logic              bad_in;
  logic              addr_unused;

  assign addr_unused = ^req_addr[31:ADDR_W+2];

  assign off_in = req_addr[1:0];
  assign m_in   = 8'({4'b0000, req_be} << off_in);
  assign mis_in = |m_in[7:4];
  assign accept = req_valid && (state == S_IDLE);

`ifdef LSU_MISALIGNED_EN
  logic [7:0]  m_q;
  logic [63:0] w_q;
  logic [31:0] hi_q;
  logic [31:0] hi_n;
  logic        mis_q;

  assign bad_in  = !be_legal(req_be);
  assign hi_n    = (state == S_RD2) ? mem_rdata : hi_q;
  assign al_data = {hi_n, lo_n};
`else
  logic [3:0]  m_q;
  logic [31:0] w_q;

  // Anything crossing a word boundary is rejected up front.
  assign bad_in  = !be_legal(req_be) || mis_in;
  assign al_data = {32'h0, lo_n};
`endif

  assign lo_n = (state == S_RD1) ? mem_rdata : lo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (accept) state_n = bad_in ? S_RESP : S_ACC1;
      end
`ifdef LSU_MISALIGNED_EN
      S_ACC1: begin
        if (!we_q)      state_n = S_RD1;
        else if (mis_q) state_n = S_ACC2;
        else            state_n = S_RESP;
      end
      S_RD1:  state_n = mis_q ? S_ACC2 : S_RESP;
      S_ACC2: state_n = we_q ? S_RESP : S_RD2;
      S_RD2:  state_n = S_RESP;
`else
      S_ACC1: state_n = we_q ? S_RESP : S_RD1;
      S_RD1:  state_n = S_RESP;
`endif
      S_RESP: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q   <= 1'b0;
      uns_q  <= 1'b0;
      err_q  <= 1'b0;
      be_q   <= '0;
      off_q  <= '0;
      word_q <= '0;
      m_q    <= '0;
      w_q    <= '0;
    end else if (accept) begin
      we_q   <= req_we;
      uns_q  <= req_unsigned;
      err_q  <= bad_in;
      be_q   <= req_be;
      off_q  <= off_in;
      word_q <= req_addr[ADDR_W+1:2];
`ifdef LSU_MISALIGNED_EN
      m_q    <= m_in;
      w_q    <= {32'h0, req_wdata} << {off_in, 3'b000};
`else
      m_q    <= m_in[3:0];
      w_q    <= req_wdata << {off_in, 3'b000};
`endif
    end
  end

`ifdef LSU_MISALIGNED_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q <= 1'b0;
      hi_q  <= '0;
    end else begin
      if (accept)          mis_q <= mis_in;
      if (state == S_RD2)  hi_q  <= mem_rdata;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lo_q <= '0;
    else if (state == S_RD1) lo_q <= mem_rdata;
  end

  lsu_load_align u_align (
    .data   (al_data),
    .off    (off_q),
    .size   (be_q),
    .uns    (uns_q),
    .result (al_res)
  );

  // Only the IDLE->RESP path is an error; stores return 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= '0;
    end else if (state_n == S_RESP && state != S_RESP) begin
      if (state == S_IDLE || we_q) rsp_rdata <= '0;
      else                         rsp_rdata <= al_res;
    end
  end

  assign req_ready = (state == S_IDLE) && !rst;
  assign rsp_valid = (state == S_RESP);
  assign rsp_err   = (state == S_RESP) && err_q;

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_wdata = '0;
    unique case (state)
      S_ACC1: begin
        mem_addr  = word_q;
        mem_we    = we_q;
        mem_be    = m_q[3:0];
        mem_wdata = w_q[31:0];
      end
`ifdef LSU_MISALIGNED_EN
      S_ACC2: begin
        mem_addr  = word_q + ADDR_W'(1);
        mem_we    = we_q;
        mem_be    = m_q[7:4];
        mem_wdata = w_q[63:32];
      end
`endif
      default: begin
        mem_addr  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed scoreboard bench for lsu_mem_port with a byte-lane
// SRAM model; covers both LSU_MISALIGNED_EN builds.
module tb_lsu_mem_port;
  import lsu_pkg::*;

  localparam int AW = 12;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [3:0]    req_be;
  logic          req_unsigned;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  lsu_mem_port #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_be       (req_be),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] sram [0:(1<<AW)-1];

  initial begin
    for (int i = 0; i < (1 << AW); i++) sram[i] = '0;
    mem_rdata = '0;
  end

  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    mem_rdata <= sram[mem_addr];
  end

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t sb[$];

  int checks;
  int failures;

  logic [AW-1:0] log_addr  [0:31];
  logic [3:0]    log_be    [0:31];
  logic [31:0]   log_wdata [0:31];
  logic          log_we    [0:31];
  logic          log_rdy   [0:31];
  logic          any_we;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic issue(input string tag,
                       input logic we,
                       input logic [3:0] be,
                       input logic uns,
                       input logic [31:0] addr,
                       input logic [31:0] wd,
                       input logic xerr,
                       input logic [31:0] xdata,
                       input int xlat);
    exp_t e;
    int   c;
    int   w;
    bit   got;
    e.err  = xerr;
    e.data = xdata;
    e.lat  = xlat;
    sb.push_back(e);
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    req_valid    = 1'b1;
    req_we       = we;
    req_be       = be;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    c      = 1;
    got    = 0;
    any_we = 1'b0;
    while (!got && c < 20) begin
      log_addr[c]  = mem_addr;
      log_be[c]    = mem_be;
      log_wdata[c] = mem_wdata;
      log_we[c]    = mem_we;
      log_rdy[c]   = req_ready;
      any_we       = any_we | mem_we;
      if (rsp_valid) got = 1;
      else begin
        @(posedge clk);
        #1;
        c++;
      end
    end
    e = sb.pop_front();
    chk({tag, " rsp"}, 32'(got), 32'd1);
    chk({tag, " lat"}, 32'(c), 32'(e.lat));
    chk({tag, " err"}, 32'(rsp_err), 32'(e.err));
    chk({tag, " data"}, rsp_rdata, e.data);
  endtask

  logic [31:0] wrap_exp;
  logic [31:0] final_exp;
  bit          seen;

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_be       = 4'h0;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    #2;
    chk("rst ready", 32'(req_ready), 32'd0);
    chk("rst valid", 32'(rsp_valid), 32'd0);
    chk("rst err", 32'(rsp_err), 32'd0);
    chk("rst rdata", rsp_rdata, 32'd0);
    chk("rst mem", {mem_wdata[27:0] | 28'(mem_addr),
                    mem_be} | 32'(mem_we), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue("sw", 1, BE_W, 0, 32'h40, 32'hDEADBEEF,
          0, 32'h0, 2);
    chk("sw addr", 32'(log_addr[1]), 32'h010);
    chk("sw be", 32'(log_be[1]), 32'hF);
    chk("sw we", 32'(log_we[1]), 32'd1);
    chk("sw wdata", log_wdata[1], 32'hDEADBEEF);
    chk("busy ready", 32'(log_rdy[1]), 32'd0);

    issue("lw", 0, BE_W, 0, 32'h40, 32'h0,
          0, 32'hDEADBEEF, 3);
    chk("lw addr", 32'(log_addr[1]), 32'h010);
    chk("lw be", 32'(log_be[1]), 32'hF);
    chk("lw we", 32'(log_we[1]), 32'd0);

    issue("sw2", 1, BE_W, 0, 32'h40, 32'h8899AABB,
          0, 32'h0, 2);
    issue("lb", 0, BE_B, 0, 32'h42, 32'h0,
          0, 32'hFFFFFF99, 3);
    issue("lbu", 0, BE_B, 1, 32'h42, 32'h0,
          0, 32'h00000099, 3);
    issue("lh", 0, BE_H, 0, 32'h42, 32'h0,
          0, 32'hFFFF8899, 3);
    issue("lhu", 0, BE_H, 1, 32'h42, 32'h0,
          0, 32'h00008899, 3);
    chk("lhu be", 32'(log_be[1]), 32'hC);

    issue("sb", 1, BE_B, 0, 32'h43, 32'h0000005A,
          0, 32'h0, 2);
    chk("sb be", 32'(log_be[1]), 32'h8);
    chk("sb lane", 32'(log_wdata[1][31:24]), 32'h5A);
    issue("sb rb", 0, BE_W, 1, 32'h40, 32'h0,
          0, 32'h5A99AABB, 3);

    issue("bad be", 1, 4'b0101, 0, 32'h40, 32'h12345678,
          1, 32'h0, 1);
    chk("bad be we", 32'(any_we), 32'd0);
    issue("bad rb", 0, BE_W, 0, 32'h40, 32'h0,
          0, 32'h5A99AABB, 3);

`ifdef LSU_MISALIGNED_EN
    issue("sw lo", 1, BE_W, 0, 32'h40, 32'h44332211,
          0, 32'h0, 2);
    issue("sw hi", 1, BE_W, 0, 32'h44, 32'h88776655,
          0, 32'h0, 2);
    issue("lw mis", 0, BE_W, 0, 32'h41, 32'h0,
          0, 32'h55443322, 5);
    chk("lw mis a1", 32'(log_addr[1]), 32'h010);
    chk("lw mis a2", 32'(log_addr[3]), 32'h011);
    chk("lw mis b2", 32'(log_be[3]), 32'h1);
    issue("sw wrap", 1, BE_W, 0, 32'h3FFF, 32'hCAFEF00D,
          0, 32'h0, 3);
    chk("wrap a2", 32'(log_addr[2]), 32'h000);
    chk("wrap b1", 32'(log_be[1]), 32'h8);
    chk("wrap b2", 32'(log_be[2]), 32'h7);
    wrap_exp = sram[0];
    chk("wrap mem0", wrap_exp, 32'h00CAFEF0);
    issue("lw wrap", 0, BE_W, 0, 32'h3FFF, 32'h0,
          0, 32'hCAFEF00D, 5);
`else
    issue("lw mis", 0, BE_W, 0, 32'h41, 32'h0,
          1, 32'h0, 1);
    issue("sw wrap", 1, BE_W, 0, 32'h3FFF, 32'hCAFEF00D,
          1, 32'h0, 1);
    chk("wrap we", 32'(any_we), 32'd0);
    wrap_exp = sram[0];
    chk("wrap mem0", wrap_exp, 32'h0);
`endif

    // Reset lands in RD1 of a load; nothing may complete.
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_be       = BE_W;
    req_unsigned = 1'b0;
`ifdef LSU_MISALIGNED_EN
    req_addr     = 32'h41;
`else
    req_addr     = 32'h40;
`endif
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid rst ready", 32'(req_ready), 32'd0);
    chk("mid rst valid", 32'(rsp_valid), 32'd0);
    chk("mid rst mem", {mem_wdata[27:0] | 28'(mem_addr),
                        mem_be} | 32'(mem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel ready", 32'(req_ready), 32'd1);
    seen = 0;
    repeat (8) begin
      seen = seen | rsp_valid | mem_we;
      @(posedge clk);
      #1;
    end
    chk("rel quiet", 32'(seen), 32'd0);

`ifdef LSU_MISALIGNED_EN
    final_exp = 32'h44332211;
`else
    final_exp = 32'h5A99AABB;
`endif
    issue("post rst", 0, BE_W, 0, 32'h40, 32'h0,
          0, final_exp, 3);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 Parameter ADDR_W, default 12, word-address width of the attached data SRAM (4*2^ADDR_W bytes).
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 req_valid  in  1  core load/store request.
REQ-006 req_ready  out  1  high only in IDLE and rst low; transfer on req_valid&&req_ready at a rising edge.
REQ-007 req_we  in  1  1=store, 0=load (decoder MemWrite).
REQ-008 req_be  in  4  size code from decoder: 0001 byte, 0011 half, 1111 word; any other value illegal.
REQ-009 req_unsigned  in  1  load zero-extends (funct3[2]).
REQ-010 req_addr  in  32  byte address; bits above ADDR_W+1 ignored.
REQ-011 req_wdata  in  32  store data, right-aligned.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  32  extended load data; 0 for stores/errors; held until next rsp_valid.
REQ-014 rsp_err  out  1  valid with rsp_valid; illegal size or unsupported misalignment.
REQ-015 mem_addr  out  ADDR_W; mem_we  out  1; mem_be  out  4; mem_wdata  out  32  SRAM port, driven only in ACC states, else all zero.
REQ-016 mem_rdata  in  32  SRAM read data, valid the cycle after the ACC cycle.

Function
REQ-017 FSM states: IDLE, ACC1, RD1, ACC2, RD2, RESP; accepted request fields registered at acceptance.
REQ-018 Offset o=addr[1:0]; lane mask M=(req_be<<o) 8 bits; shifted data W=req_wdata<<(8*o) 64 bits; misaligned iff M[7:4]!=0.
REQ-019 ACC1: mem_addr=addr[ADDR_W+1:2], mem_be=M[3:0], mem_wdata=W[31:0], mem_we=req_we.
REQ-020 ACC2: mem_addr=word+1 modulo 2^ADDR_W (wraps to 0), mem_be=M[7:4], mem_wdata=W[63:32].
REQ-021 Transitions: IDLE->ACC1 on accept; ACC1->RD1 (load) or ->ACC2 (misaligned store) or ->RESP; RD1 captures mem_rdata as lo, ->ACC2 if misaligned else RESP; ACC2->RD2 (load) or RESP; RD2 captures hi; RESP->IDLE.
REQ-022 Illegal req_be: IDLE->RESP directly, rsp_err=1, no mem activity.
REQ-023 Latency from accept edge (cycle 0): aligned store rsp in cycle 2, aligned load cycle 3, misaligned store cycle 3, misaligned load cycle 5, error cycle 1.
REQ-024 Load result: ({hi,lo}>>(8*o)) masked to size; sign-extended from bit 7/15 unless req_unsigned; word ignores req_unsigned.
REQ-025 Stores never modify bytes outside M; req_valid outside IDLE is ignored (no queueing).

Reset
REQ-026 While rst high: state IDLE, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, all mem_* outputs 0, immediately (asynchronous).
REQ-027 Reset mid-transaction abandons it: no rsp_valid, a pending ACC2 write is never issued; req_ready=1 in first cycle after release.

Configuration
REQ-028 Macro LSU_MISALIGNED_EN defined: misaligned accesses split into two word accesses per REQ-020/021.
REQ-029 Macro undefined: misaligned request goes IDLE->RESP with rsp_err=1, no mem activity; ACC2/RD2 not synthesized.

Structure
REQ-030 Shared package lsu_pkg holds state encodings, BE size codes (BE_B/BE_H/BE_W) and the ADDR_W default.
REQ-031 One sub-module lsu_load_align: combinational {hi,lo}, offset, size, unsigned -> 32-bit result.

Verification
REQ-032 SW 0xDEADBEEF @0x40, then LW @0x40 -> mem_addr 0x010, mem_be 1111; rsp_rdata 0xDEADBEEF in cycle 3.
REQ-033 Word 0x010=0x8899AABB: LB @0x42 -> 0xFFFFFF99; LBU -> 0x00000099; LH @0x42 -> 0xFFFF8899; LHU -> 0x00008899.
REQ-034 SB 0x5A @0x43 -> mem_be 1000, mem_wdata[31:24]=0x5A; readback word 0x5A99AABB.
REQ-035 Macro on: words 0x010=0x44332211, 0x011=0x88776655, LW @0x41 -> two reads, rsp_rdata 0x55443322 cycle 5; SW @0x3FFF -> ACC2 mem_addr 0x000; macro off: rsp_err=1 cycle 1.
REQ-036 req_be=0101 -> rsp_err=1 in cycle 1, mem_we never asserted.
REQ-037 rst pulse during RD1 of misaligned load -> no rsp_valid, mem_* zero, req_ready=1 first cycle after release.
